line_fetch: RTL and testbench
=============================

LINE_FETCH -- requirements
Module: line_fetch

Interface
REQ-001 SHALL have ports (name, direction, width, meaning) as listed below; clock and reset come first.
REQ-002 clk  in  1  pixel clock, one pixel per cycle.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 i_line_start  in  1  one-cycle pulse at end of each scanline.
REQ-005 i_line  in  8  framebuffer line to prefetch, sampled on i_line_start.
REQ-006 i_h_act, i_v_act  in  1 each  active-pixel qualifiers.
REQ-007 mem_req  out  1  word fetch request.
REQ-008 mem_addr  out  14  word address {line, word[5:0]}.
REQ-009 mem_ack  in  1  data valid, one cycle.
REQ-010 mem_data  in  16  four 4-bit palette indices.
REQ-011 pal_we  in  1  palette write strobe.
REQ-012 pal_idx  in  4  palette entry index.
REQ-013 pal_data  in  12  palette entry value {R4,G4,B4}.
REQ-014 VGA_R4, VGA_G4, VGA_B4  out  4 each  pixel colour to the video timing stage.

Function
REQ-015 Two 64x16 line-buffer banks SHALL be used: one for display, one for fill; both roles swap on every i_line_start.
REQ-016 Fetch FSM states SHALL be IDLE, REQ and WAIT.
REQ-017 IDLE -> REQ on i_line_start, with word counter = 0 and line register = i_line.
REQ-018 In REQ and WAIT, mem_req SHALL be 1 and mem_addr SHALL be {line, word}; both SHALL be held stable until mem_ack.
REQ-019 On mem_ack, mem_data SHALL be written into fill bank[word] and word SHALL increment; word 63 acked -> IDLE, otherwise stay in REQ.
REQ-020 mem_ack outside REQ/WAIT SHALL be ignored.
REQ-021 i_line_start while fetch is incomplete (underrun): the fetch SHALL be aborted; swap, then restart at word 0 for the new i_line; unfetched entries of the displayed bank keep stale contents.
REQ-022 i_line_start and mem_ack in the same cycle: the acked data SHALL be written to the bank becoming display; the restart still occurs; it counts as underrun unless word was 63.
REQ-023 Pixel counter (8-bit) SHALL clear on i_line_start, increment on i_h_act, and wrap 255 -> 0.
REQ-024 Pixel p SHALL use display bank[p[7:2]] bits [4*p[1:0]+3 : 4*p[1:0]].
REQ-025 Output SHALL be registered with latency exactly 1 cycle from the i_h_act cycle to RGB.
REQ-026 RGB SHALL be 0 when i_h_act or i_v_act was low in that cycle.
REQ-027 Palette: 16x12 registers, written synchronously on pal_we; a read of an entry in the same cycle it is written SHALL return the old value.

Reset
REQ-028 Reset SHALL force FSM = IDLE, mem_req = 0, mem_addr = 0, word = 0, pixel counter = 0, bank select = 0, and RGB outputs = 0.
REQ-029 Palette and line buffers SHALL NOT be reset.
REQ-030 Reset asserted mid-fetch SHALL drop mem_req asynchronously; no write SHALL occur from a mem_ack during reset.

Configuration
REQ-031 With LINE_FETCH_UNDERRUN_CNT_EN defined: output o_underrun_cnt (8 bits) SHALL count underrun events per REQ-021/REQ-022, saturate at 255, and reset to 0.
REQ-032 Without LINE_FETCH_UNDERRUN_CNT_EN: the port and counter SHALL be absent and the rest of the behaviour SHALL be identical.

Verification
REQ-033 Fetch with 0-wait ack (ack the cycle after req): i_line=0x05 -> mem_addr 0x0140..0x017F in order, FSM IDLE after 64 acks, no underrun.
REQ-034 Palette: entry 3 = 0xF80, word 0 = 0x3210, next line displayed -> pixel 0 uses entry 0, pixel 3 outputs R4=F, G4=8, B4=0 one cycle after its i_h_act.
REQ-035 Ack withheld after word 10, then i_line_start -> addr restarts at word 0 of new line; o_underrun_cnt increments by 1.
REQ-036 i_line_start coincident with ack of word 63 -> no underrun; data is visible at pixels 252..255.
REQ-037 reset_n low while mem_req=1 -> mem_req=0 immediately; after release, FSM is IDLE and RGB=0 until the next line.
REQ-038 300 consecutive underruns -> o_underrun_cnt holds 255.

Source files
------------

// File: rtl/line_fetch.sv
// line_fetch: double-buffered scanline prefetch from the framebuffer with 4-bit palette lookup.
// Optional feature: define LINE_FETCH_UNDERRUN_CNT_EN to add the o_underrun_cnt output.
module line_fetch (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_line_start,
  input  logic [7:0]  i_line,
  input  logic        i_h_act,
  input  logic        i_v_act,
  output logic        mem_req,
  output logic [13:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  input  logic        pal_we,
  input  logic [3:0]  pal_idx,
  input  logic [11:0] pal_data,
  output logic [3:0]  VGA_R4,
  output logic [3:0]  VGA_G4,
  output logic [3:0]  VGA_B4
`ifdef LINE_FETCH_UNDERRUN_CNT_EN
  ,
  output logic [7:0]  o_underrun_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state_q, state_d;
  logic [5:0]  word_q, word_d;
  logic [7:0]  line_q, line_d;
  logic        bank_sel_q, bank_sel_d;
  logic [7:0]  pix_q, pix_d;
  logic [11:0] rgb_q, rgb_d;
  logic        buf_we;
  logic [15:0] disp_word;
  logic [3:0]  pix_nib;

  // bank_sel_q selects the display bank; the other bank is being filled
  logic [15:0] line_buf [2][64];
  logic [11:0] pal_mem [16];

  // mem_req comes straight from the state so reset drops it without waiting for a clock
  assign mem_req  = (state_q != IDLE);
  assign mem_addr = {line_q, word_q};
  assign buf_we   = mem_req && mem_ack;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    line_d     = line_q;
    bank_sel_d = bank_sel_q;
    case (state_q)
      IDLE: ;
      REQ, WAIT: begin
        if (mem_ack) begin
          word_d  = word_q + 6'd1;
          state_d = (word_q == 6'd63) ? IDLE : REQ;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
    // a new line always wins: swap banks and restart, abandoning any unfinished fetch
    if (i_line_start) begin
      state_d    = REQ;
      word_d     = '0;
      line_d     = i_line;
      bank_sel_d = ~bank_sel_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      word_q     <= '0;
      line_q     <= '0;
      bank_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      line_q     <= line_d;
      bank_sel_q <= bank_sel_d;
    end
  end

  // an ack coinciding with i_line_start lands in the bank that is about to be displayed
  always_ff @(posedge clk) begin
    if (buf_we) begin
      line_buf[~bank_sel_q][word_q] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (pal_we) begin
      pal_mem[pal_idx] <= pal_data;
    end
  end

  always_comb begin
    disp_word = line_buf[bank_sel_q][pix_q[7:2]];
    pix_nib   = disp_word[{pix_q[1:0], 2'b00} +: 4];
    pix_d     = pix_q;
    if (i_line_start) begin
      pix_d = '0;
    end else if (i_h_act) begin
      pix_d = pix_q + 8'd1;
    end
    rgb_d = '0;
    if (i_h_act && i_v_act) begin
      rgb_d = pal_mem[pix_nib];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_q <= '0;
      rgb_q <= '0;
    end else begin
      pix_q <= pix_d;
      rgb_q <= rgb_d;
    end
  end

  assign VGA_R4 = rgb_q[11:8];
  assign VGA_G4 = rgb_q[7:4];
  assign VGA_B4 = rgb_q[3:0];

`ifdef LINE_FETCH_UNDERRUN_CNT_EN
  logic       underrun;
  logic [7:0] urun_cnt_q, urun_cnt_d;

  // finishing word 63 in the same cycle as the new line still counts as on time
  always_comb begin
    underrun   = i_line_start && mem_req && !(mem_ack && (word_q == 6'd63));
    urun_cnt_d = urun_cnt_q;
    if (underrun && (urun_cnt_q != 8'hFF)) begin
      urun_cnt_d = urun_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      urun_cnt_q <= '0;
    end else begin
      urun_cnt_q <= urun_cnt_d;
    end
  end

  assign o_underrun_cnt = urun_cnt_q;
`endif

endmodule

// File: tb/tb_line_fetch.sv
// Self-checking bench for line_fetch: memory responder, bank/palette model and RGB scoreboard.
module tb_line_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_line_start = 1'b0;
  logic [7:0]  i_line = '0;
  logic        i_h_act = 1'b0;
  logic        i_v_act = 1'b0;
  logic        mem_req;
  logic [13:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data = '0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_idx = '0;
  logic [11:0] pal_data = '0;
  logic [3:0]  vga_r, vga_g, vga_b;
`ifdef LINE_FETCH_UNDERRUN_CNT_EN
  logic [7:0]  urun_cnt;
`endif

  always #5 clk = ~clk;

  line_fetch dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_line_start (i_line_start),
    .i_line       (i_line),
    .i_h_act      (i_h_act),
    .i_v_act      (i_v_act),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data),
    .pal_we       (pal_we),
    .pal_idx      (pal_idx),
    .pal_data     (pal_data),
    .VGA_R4       (vga_r),
    .VGA_G4       (vga_g),
    .VGA_B4       (vga_b)
`ifdef LINE_FETCH_UNDERRUN_CNT_EN
    ,
    .o_underrun_cnt (urun_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [11:0] pal_model [16];
  logic [15:0] mb [2][64];
  bit          mv [2][64];
  bit          m_bank = 1'b0;
  bit          m_fetching = 1'b0;
  int          m_word = 0;
  logic [7:0]  m_line = '0;
  logic [7:0]  m_pix = '0;
  int          m_under = 0;

  // stimulus controls
  bit          nxt_ls = 1'b0;
  logic [7:0]  nxt_line = '0;
  bit          nxt_h = 1'b0;
  bit          nxt_v = 1'b0;
  bit          nxt_pal_we = 1'b0;
  logic [3:0]  nxt_pal_idx = '0;
  logic [11:0] nxt_pal_data = '0;
  bit          resp_en = 1'b0;
  int          resp_wait = 1;
  int          ack_stop = 64;
  int          wait_cnt = 0;

  typedef struct {
    bit          chk;
    logic [11:0] v;
  } pix_t;

  logic [13:0] addr_q [$];
  pix_t        px_q [$];

  function automatic logic [15:0] mem_word(input logic [7:0] ln, input int w);
    int t;
    if (ln == 8'h05 && w == 0) return 16'h3210;
    t = (int'(ln) * 977) ^ (w * 4099) ^ 32'h5a3c;
    return t[15:0];
  endfunction

  // One clock: score last cycle's outputs, advance the model, drive the next inputs.
  task automatic cycle();
    pix_t        e;
    logic [5:0]  wi;
    logic [15:0] wd;
    logic [3:0]  nib;
    bit          ack;
    logic [15:0] dat;
    @(negedge clk);
    if (px_q.size() > 0) begin
      e = px_q.pop_front();
      if (e.chk) begin
        checks++;
        if ({vga_r, vga_g, vga_b} !== e.v) begin
          errors++;
          $display("FAIL rgb: got %h expected %h", {vga_r, vga_g, vga_b}, e.v);
        end
      end
    end
    checks++;
    if (mem_req !== m_fetching) begin
      errors++;
      $display("FAIL mem_req: got %b expected %b", mem_req, m_fetching);
    end
    e.chk = 1'b1;
    e.v   = '0;
    if (nxt_h && nxt_v) begin
      wi = m_pix[7:2];
      if (mv[m_bank][wi]) begin
        wd    = mb[m_bank][wi];
        nib   = wd[{m_pix[1:0], 2'b00} +: 4];
        e.v   = pal_model[nib];
      end else begin
        e.chk = 1'b0;
      end
    end
    px_q.push_back(e);
    if (nxt_pal_we) pal_model[nxt_pal_idx] = nxt_pal_data;
    ack = 1'b0;
    dat = '0;
    if (resp_en && m_fetching && mem_req === 1'b1 && addr_q.size() > 0) begin
      checks++;
      if (mem_addr !== addr_q[0]) begin
        errors++;
        $display("FAIL mem_addr: got %h expected %h", mem_addr, addr_q[0]);
      end
      if (m_word < ack_stop) begin
        if (wait_cnt >= resp_wait) begin
          ack = 1'b1;
          dat = mem_word(m_line, m_word);
          void'(addr_q.pop_front());
          mb[!m_bank][6'(m_word)] = dat;
          mv[!m_bank][6'(m_word)] = 1'b1;
          m_word++;
          if (m_word == 64) m_fetching = 1'b0;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
    if (nxt_ls) begin
      if (m_fetching && m_under < 255) m_under++;
      m_bank     = !m_bank;
      m_fetching = 1'b1;
      m_word     = 0;
      m_line     = nxt_line;
      wait_cnt   = 0;
      addr_q.delete();
      for (int w = 0; w < 64; w++) addr_q.push_back({nxt_line, 6'(w)});
      m_pix = '0;
    end else if (nxt_h) begin
      m_pix = m_pix + 8'd1;
    end
    i_line_start = nxt_ls;
    i_line       = nxt_line;
    i_h_act      = nxt_h;
    i_v_act      = nxt_v;
    mem_ack      = ack;
    mem_data     = dat;
    pal_we       = nxt_pal_we;
    pal_idx      = nxt_pal_idx;
    pal_data     = nxt_pal_data;
    nxt_ls       = 1'b0;
    nxt_pal_we   = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++;
    if (mem_addr !== 14'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++;
    if ({vga_r, vga_g, vga_b} !== 12'h0) begin errors++; $display("FAIL reset_rgb: got %h expected 0", {vga_r, vga_g, vga_b}); end
`ifdef LINE_FETCH_UNDERRUN_CNT_EN
    checks++;
    if (urun_cnt !== 8'h0) begin errors++; $display("FAIL reset_urun: got %0d expected 0", urun_cnt); end
`endif
    reset_n = 1'b1;
  endtask

  task automatic test_palette_load();
    for (int i = 0; i < 16; i++) begin
      nxt_pal_we   = 1'b1;
      nxt_pal_idx  = 4'(i);
      nxt_pal_data = (i == 3) ? 12'hF80 : (i == 0) ? 12'h123 : 12'($urandom);
      cycle();
    end
    cycle();
  endtask

  task automatic test_fetch();
    int n = 0;
    resp_en = 1'b1; resp_wait = 1; ack_stop = 64;
    nxt_ls = 1'b1; nxt_line = 8'h05;
    cycle();
    while (m_fetching && n < 400) begin cycle(); n++; end
    checks++;
    if (m_fetching) begin errors++; $display("FAIL fetch_timeout: got %0d acks expected 64", m_word); end
    cycle();
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_idle: got %b expected 0", mem_req); end
`ifdef LINE_FETCH_UNDERRUN_CNT_EN
    checks++;
    if (urun_cnt !== 8'd0) begin errors++; $display("FAIL fetch_urun: got %0d expected 0", urun_cnt); end
`endif
  endtask

  task automatic test_display();
    resp_en = 1'b0;
    nxt_ls = 1'b1; nxt_line = 8'h06;
    cycle();
    cycle();
    for (int p = 0; p < 8; p++) begin
      nxt_h = 1'b1; nxt_v = 1'b1;
      if (p == 3) begin
        nxt_pal_we = 1'b1; nxt_pal_idx = 4'd3; nxt_pal_data = 12'h0F0;
      end
      cycle();
      if (p == 3) begin
        @(posedge clk); #1;
        checks++;
        if ({vga_r, vga_g, vga_b} !== 12'hF80) begin
          errors++;
          $display("FAIL pixel3_rgb: got %h expected f80", {vga_r, vga_g, vga_b});
        end
      end
    end
    for (int p = 0; p < 4; p++) begin nxt_h = 1'b1; nxt_v = 1'b0; cycle(); end
    for (int p = 0; p < 2; p++) begin nxt_h = 1'b0; nxt_v = 1'b1; cycle(); end
    nxt_h = 1'b0; nxt_v = 1'b0;
    cycle();
  endtask

  task automatic test_underrun();
    int n = 0;
    resp_en = 1'b1; resp_wait = 1; ack_stop = 11;
    while (m_word < 11 && n < 100) begin cycle(); n++; end
    repeat (4) cycle();
    nxt_ls = 1'b1; nxt_line = 8'h09;
    cycle();
    @(posedge clk); #1;
    checks++;
    if (mem_addr !== 14'h240) begin errors++; $display("FAIL underrun_restart_addr: got %h expected 240", mem_addr); end
`ifdef LINE_FETCH_UNDERRUN_CNT_EN
    checks++;
    if (urun_cnt !== 8'd1) begin errors++; $display("FAIL underrun_cnt: got %0d expected 1", urun_cnt); end
`endif
    for (int p = 0; p < 48; p++) begin nxt_h = 1'b1; nxt_v = 1'b1; cycle(); end
    nxt_h = 1'b0; nxt_v = 1'b0;
    cycle();
  endtask

  task automatic test_coincident();
    int n = 0;
    resp_en = 1'b1; resp_wait = 1; ack_stop = 63;
    while (m_word < 63 && n < 300) begin cycle(); n++; end
    resp_wait = 0; ack_stop = 64;
    nxt_ls = 1'b1; nxt_line = 8'h0A;
    cycle();
    resp_en = 1'b0;
    cycle();
`ifdef LINE_FETCH_UNDERRUN_CNT_EN
    checks++;
    if (urun_cnt !== 8'd1) begin errors++; $display("FAIL coincident_urun: got %0d expected 1", urun_cnt); end
`endif
    for (int p = 0; p < 252; p++) begin nxt_h = 1'b1; nxt_v = 1'b0; cycle(); end
    for (int p = 0; p < 5; p++) begin nxt_h = 1'b1; nxt_v = 1'b1; cycle(); end
    nxt_h = 1'b0; nxt_v = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic test_reset_midfetch();
    @(negedge clk);
    #1;
    mem_ack  = 1'b1;
    mem_data = 16'hFFFF;
    reset_n  = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL async_req_drop: got %b expected 0", mem_req); end
    checks++;
    if (mem_addr !== 14'h0) begin errors++; $display("FAIL async_addr: got %h expected 0", mem_addr); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    mem_ack  = 1'b0;
    mem_data = '0;
    m_bank = 1'b0; m_fetching = 1'b0; m_word = 0; m_pix = '0; m_under = 0; wait_cnt = 0;
    addr_q.delete();
    px_q.delete();
    repeat (5) cycle();
    checks++;
    if ({vga_r, vga_g, vga_b} !== 12'h0) begin errors++; $display("FAIL post_reset_rgb: got %h expected 0", {vga_r, vga_g, vga_b}); end
`ifdef LINE_FETCH_UNDERRUN_CNT_EN
    checks++;
    if (urun_cnt !== 8'd0) begin errors++; $display("FAIL post_reset_urun: got %0d expected 0", urun_cnt); end
`endif
    nxt_ls = 1'b1; nxt_line = 8'h0C;
    cycle();
    for (int p = 0; p < 4; p++) begin nxt_h = 1'b1; nxt_v = 1'b1; cycle(); end
    nxt_h = 1'b0; nxt_v = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic test_underrun_sat();
    resp_en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      nxt_ls = 1'b1; nxt_line = 8'(i);
      cycle();
      cycle();
    end
`ifdef LINE_FETCH_UNDERRUN_CNT_EN
    checks++;
    if (urun_cnt !== 8'd255) begin errors++; $display("FAIL underrun_sat: got %0d expected 255", urun_cnt); end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_palette_load();
    test_fetch();
    test_display();
    test_underrun();
    test_coincident();
    test_reset_midfetch();
    test_underrun_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
